// File: rtl/exe_hazard_ctrl_if.sv
// rtl/exe_hazard_ctrl_if.sv - ID-stage request and hazard/forwarding response bundle
interface exe_hazard_ctrl_if;
    logic        fwd_en;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic        id_mem_read;
    logic        branch_taken;
    logic        stall;
    logic        flush;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [15:0] stall_count;

    modport master (
        output fwd_en, id_valid, id_src1, id_src2, id_two_src,
               id_wb_en, id_dest, id_mem_read, branch_taken,
        input  stall, flush, sel_src1, sel_src2, stall_count
    );

    modport slave (
        input  fwd_en, id_valid, id_src1, id_src2, id_two_src,
               id_wb_en, id_dest, id_mem_read, branch_taken,
        output stall, flush, sel_src1, sel_src2, stall_count
    );
endinterface

// File: rtl/exe_hazard_ctrl.sv
// rtl/exe_hazard_ctrl.sv - execute-stage hazard detection, forwarding selects and stall counter
module exe_hazard_ctrl (
    input logic              clk,
    input logic              rst,
    exe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Shadow of the EXE and MEM slots. The WB slot is not kept: the register
    // file is write-before-read, so a producer in WB never forwards or stalls.
    logic        e_valid;
    logic        e_wb_en;
    logic [3:0]  e_dest;
    logic        e_mem_read;
    logic        m_valid;
    logic        m_wb_en;
    logic [3:0]  m_dest;

    logic [1:0]  sel1_q;
    logic [1:0]  sel2_q;
    logic [15:0] count_q;

    logic        me1, me2, mm1, mm2;
    logic        hz1, hz2;
    logic        stall_c;
    logic        load_e;
    logic [1:0]  sel1_d, sel2_d;

    // Hazard detection and next-select generation for the instruction in ID
    always_comb begin
        me1 = e_valid & e_wb_en & (e_dest == bus.id_src1);
        me2 = e_valid & e_wb_en & (e_dest == bus.id_src2) & bus.id_two_src;
        mm1 = m_valid & m_wb_en & (m_dest == bus.id_src1);
        mm2 = m_valid & m_wb_en & (m_dest == bus.id_src2) & bus.id_two_src;

        if (bus.fwd_en) begin
            hz1 = me1 & e_mem_read;
            hz2 = me2 & e_mem_read;
        end else begin
            hz1 = me1 | mm1;
            hz2 = me2 | mm2;
        end

        // A taken branch kills the ID instruction, so it must not also stall
        stall_c = bus.id_valid & (hz1 | hz2) & ~bus.branch_taken;
        load_e  = bus.id_valid & ~stall_c & ~bus.branch_taken;

        // The youngest producer (in E now, in MEM when the consumer executes) wins
        sel1_d = SEL_REG;
        sel2_d = SEL_REG;
        if (bus.fwd_en) begin
            if (me1)      sel1_d = SEL_MEM;
            else if (mm1) sel1_d = SEL_WB;
            if (me2)      sel2_d = SEL_MEM;
            else if (mm2) sel2_d = SEL_WB;
        end
    end

    // Advance the shadow slots, register the selects and count stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_valid    <= 1'b0;
            e_wb_en    <= 1'b0;
            e_dest     <= 4'd0;
            e_mem_read <= 1'b0;
            m_valid    <= 1'b0;
            m_wb_en    <= 1'b0;
            m_dest     <= 4'd0;
            sel1_q     <= SEL_REG;
            sel2_q     <= SEL_REG;
            count_q    <= 16'd0;
        end else begin
            m_valid <= e_valid;
            m_wb_en <= e_wb_en;
            m_dest  <= e_dest;
            if (load_e) begin
                e_valid    <= 1'b1;
                e_wb_en    <= bus.id_wb_en;
                e_dest     <= bus.id_dest;
                e_mem_read <= bus.id_mem_read;
                sel1_q     <= sel1_d;
                sel2_q     <= sel2_d;
            end else begin
                e_valid    <= 1'b0;
                e_wb_en    <= 1'b0;
                e_dest     <= 4'd0;
                e_mem_read <= 1'b0;
                sel1_q     <= SEL_REG;
                sel2_q     <= SEL_REG;
            end
            if (stall_c && count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.flush       = bus.branch_taken;
    assign bus.sel_src1    = sel1_q;
    assign bus.sel_src2    = sel2_q;
    assign bus.stall_count = count_q;
endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// tb/tb_exe_hazard_ctrl.sv - table-driven scoreboard bench for exe_hazard_ctrl
module tb_exe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exe_hazard_ctrl_if bus ();
    exe_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        fwd, vld;
        logic [3:0]  s1, s2;
        logic        two, wb;
        logic [3:0]  dst;
        logic        mr, br;
        logic        e_stall, e_flush;
        logic [1:0]  e_sel1, e_sel2;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct {
        logic [1:0]  sel1, sel2;
        logic [15:0] cnt;
        int          idx;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[27];
    int   pass_cnt = 0;
    int   total = 0;

    function automatic vec_t mk(input logic fwd, input logic vld, input logic [3:0] s1,
                                input logic [3:0] s2, input logic two, input logic wb,
                                input logic [3:0] dst, input logic mr, input logic br,
                                input logic es, input logic ef, input logic [1:0] e1,
                                input logic [1:0] e2, input logic [15:0] ec);
        vec_t v;
        v.fwd = fwd; v.vld = vld; v.s1 = s1; v.s2 = s2; v.two = two; v.wb = wb;
        v.dst = dst; v.mr = mr; v.br = br; v.e_stall = es; v.e_flush = ef;
        v.e_sel1 = e1; v.e_sel2 = e2; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.fwd_en = v.fwd; bus.id_valid = v.vld; bus.id_src1 = v.s1; bus.id_src2 = v.s2;
        bus.id_two_src = v.two; bus.id_wb_en = v.wb; bus.id_dest = v.dst;
        bus.id_mem_read = v.mr; bus.branch_taken = v.br;
    endtask

    // One ID cycle: combinational outputs checked mid-cycle, registered ones via the scoreboard
    task automatic apply(input vec_t v, input int idx);
        exp_t e, got;
        @(negedge clk);
        drive(v);
        #1;
        chk("stall", idx, {15'd0, bus.stall}, {15'd0, v.e_stall});
        chk("flush", idx, {15'd0, bus.flush}, {15'd0, v.e_flush});
        e.sel1 = v.e_sel1; e.sel2 = v.e_sel2; e.cnt = v.e_cnt; e.idx = idx;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sel_src1", got.idx, {14'd0, bus.sel_src1}, {14'd0, got.sel1});
        chk("sel_src2", got.idx, {14'd0, bus.sel_src2}, {14'd0, got.sel2});
        chk("stall_count", got.idx, bus.stall_count, got.cnt);
    endtask

    initial begin
        //            fwd vld s1  s2  two wb dst mr br | st fl s1 s2 cnt
        tbl[0]  = mk(1, 1, 2,  3,  1, 1, 1,  0, 0,  0, 0, 0, 0, 0);  // ADD r1
        tbl[1]  = mk(1, 1, 1,  3,  1, 1, 2,  0, 0,  0, 0, 1, 0, 0);  // SUB r2,r1,r3
        tbl[2]  = mk(1, 1, 7,  0,  0, 1, 6,  0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 8,  9,  1, 1, 1,  0, 0,  0, 0, 0, 0, 0);  // ADD r1
        tbl[4]  = mk(1, 1, 10, 0,  0, 1, 7,  0, 0,  0, 0, 0, 0, 0);  // unrelated
        tbl[5]  = mk(1, 1, 5,  1,  1, 1, 4,  0, 0,  0, 0, 0, 2, 0);  // ORR r4,r5,r1
        tbl[6]  = mk(1, 1, 11, 0,  0, 1, 2,  1, 0,  0, 0, 0, 0, 0);  // LDR r2
        tbl[7]  = mk(1, 1, 2,  2,  1, 1, 3,  0, 0,  1, 0, 0, 0, 1);  // ADD r3,r2,r2 stalls
        tbl[8]  = mk(1, 1, 2,  2,  1, 1, 3,  0, 0,  0, 0, 2, 2, 1);
        tbl[9]  = mk(0, 1, 12, 13, 1, 1, 1,  0, 0,  0, 0, 0, 0, 1);  // ADD r1, no fwd
        tbl[10] = mk(0, 1, 1,  0,  1, 1, 2,  0, 0,  1, 0, 0, 0, 2);  // SUB r2,r1,r0
        tbl[11] = mk(0, 1, 1,  0,  1, 1, 2,  0, 0,  1, 0, 0, 0, 3);
        tbl[12] = mk(0, 1, 1,  0,  1, 1, 2,  0, 0,  0, 0, 0, 0, 3);
        tbl[13] = mk(1, 1, 14, 0,  0, 1, 5,  1, 0,  0, 0, 0, 0, 3);  // LDR r5
        tbl[14] = mk(1, 1, 5,  5,  1, 1, 6,  0, 1,  0, 1, 0, 0, 3);  // load-use + branch
        tbl[15] = mk(1, 1, 6,  5,  1, 1, 8,  1, 0,  0, 0, 0, 2, 3);  // E must be a bubble
        tbl[16] = mk(1, 0, 8,  8,  1, 1, 9,  1, 0,  0, 0, 0, 0, 3);  // invalid ID
        tbl[17] = mk(1, 1, 8,  0,  0, 1, 10, 0, 0,  0, 0, 2, 0, 3);
        tbl[18] = mk(1, 1, 10, 0,  0, 0, 9,  0, 0,  0, 0, 1, 0, 3);  // no writeback
        tbl[19] = mk(1, 1, 9,  0,  0, 1, 11, 0, 0,  0, 0, 0, 0, 3);
        tbl[20] = mk(1, 1, 0,  0,  0, 1, 9,  0, 0,  0, 0, 0, 0, 3);
        tbl[21] = mk(1, 1, 0,  0,  0, 1, 9,  0, 0,  0, 0, 0, 0, 3);
        tbl[22] = mk(1, 1, 9,  9,  0, 1, 12, 0, 0,  0, 0, 1, 0, 3);  // E beats M
        tbl[23] = mk(0, 1, 9,  0,  0, 1, 14, 0, 0,  1, 0, 0, 0, 4);  // producer in M
        tbl[24] = mk(0, 1, 9,  0,  0, 1, 14, 0, 0,  0, 0, 0, 0, 4);
        tbl[25] = mk(1, 1, 0,  0,  0, 1, 13, 1, 0,  0, 0, 0, 0, 4);  // LDR r13
        tbl[26] = mk(1, 1, 0,  13, 0, 1, 15, 0, 0,  0, 0, 0, 0, 4);  // unused src2

        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_src1", 0, {14'd0, bus.sel_src1}, 16'd0);
        chk("rst_sel_src2", 0, {14'd0, bus.sel_src2}, 16'd0);
        chk("rst_stall_count", 0, bus.stall_count, 16'd0);
        chk("rst_stall", 0, {15'd0, bus.stall}, 16'd0);
        chk("rst_flush", 0, {15'd0, bus.flush}, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 27; i++) apply(tbl[i], i);

        // Reset asserted in the middle of a load-use stall
        apply(mk(1, 1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 4), 100);
        apply(mk(1, 1, 4, 0, 0, 1, 2, 1, 0, 0, 0, 1, 0, 4), 101);
        @(negedge clk);
        drive(mk(1, 1, 2, 2, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("midrst_stall_before", 102, {15'd0, bus.stall}, 16'd1);
        rst = 1'b0;
        #1;
        chk("midrst_stall", 102, {15'd0, bus.stall}, 16'd0);
        chk("midrst_sel_src1", 102, {14'd0, bus.sel_src1}, 16'd0);
        chk("midrst_stall_count", 102, bus.stall_count, 16'd0);
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;

        // Saturation: preload the counter just below the limit
        @(posedge clk);
        #2;
        force dut.count_q = 16'hFFFE;
        #1;
        release dut.count_q;
        #1;
        chk("preload", 200, bus.stall_count, 16'hFFFE);
        apply(mk(0, 1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 16'hFFFE), 201);
        apply(mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 16'hFFFF), 202);
        apply(mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 1, 0, 0, 0, 16'hFFFF), 203);
        apply(mk(0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 16'hFFFF), 204);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/exe_hazard_ctrl.md
# exe_hazard_ctrl

Hazard and forwarding controller for the execute stage. It keeps its own shadow of the destination, write-back and load information for the EXE, MEM and WB pipeline slots. From that shadow it generates the registered operand selects (`sel_src1`, `sel_src2`) that steer the execute-stage operand muxes between the register value, the MEM-stage result and the WB-stage result. It also issues the ID-stage stall for load-use and no-forwarding hazards, and the flush on a taken branch, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- No parameters. Register index width is fixed at 4, so 16 architectural registers are tracked.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fwd_en` in 1: 1 enables forwarding; 0 resolves every hazard by stalling.
- `id_valid` in 1: ID holds a real instruction.
- `id_src1` in 4: first source register (Rn).
- `id_src2` in 4: second source register (Rm, or Rd for stores).
- `id_two_src` in 1: `id_src2` is actually read.
- `id_wb_en` in 1: ID instruction writes a register.
- `id_dest` in 4: its destination register.
- `id_mem_read` in 1: ID instruction is a load.
- `branch_taken` in 1: taken branch resolved in EXE this cycle.
- `stall` out 1: hold PC and IF/ID; insert a bubble into EXE.
- `flush` out 1: invalidate IF/ID and the instruction entering EXE.
- `sel_src1` out 2: operand-1 select for the instruction in EXE.
- `sel_src2` out 2: operand-2 select for the instruction in EXE.
- `stall_count` out 16: saturating count of stalled cycles.

## Operation
- Select encoding: 00 = register value, 01 = MEM result, 10 = WB result. 11 is never driven.
- Shadow slots: E, M and W, each holding {valid, wb_en, dest, mem_read}. They shift every cycle as E→M→W; W is dropped.
- The E slot loads the ID fields only when `id_valid & !stall & !flush`. Otherwise E loads a bubble (valid=0).
- Match definitions:
  - `mE(r)` = E.valid & E.wb_en & E.dest==r.
  - `mM(r)` = M.valid & M.wb_en & M.dest==r.
- Source 2 participates only when `id_two_src`=1.
- The register file is write-before-read, so a producer in W needs no forwarding and no stall.
- Stall condition:
  - If `fwd_en`=1: stall when `mE(src)` & E.mem_read for any used source (load-use).
  - If `fwd_en`=0: stall when `mE(src)` or `mM(src)` for any used source.
  - `stall` additionally requires `id_valid`, and is forced to 0 when `branch_taken`=1.
- `flush` = `branch_taken`, combinational.
- Select generation, computed per source in ID and registered when E loads a real instruction:
  - If `fwd_en`=0, the select is 00.
  - Else if `mE(src)`, the select is 01. The producer will be in MEM when the consumer reaches EXE.
  - Else if `mM(src)`, the select is 10. The producer will be in WB.
  - Else the select is 00.
  - `mE` has priority over `mM`, so the youngest producer wins.
- Unused source 2 yields `sel_src2` = 00.
- When E loads a bubble, both selects register 00.
- After a load-use stall, the load has moved to M. The re-evaluated consumer therefore gets select 10.
- Simultaneous `branch_taken` and stall condition: flush wins. `stall`=0, E loads a bubble, and the counter does not increment.
- `stall_count` increments by 1 on each cycle with `stall`=1 and saturates at 16'hFFFF.

## Timing
- Reset (`rst`=0), asynchronous:
  - all slots invalid;
  - `sel_src1` = `sel_src2` = 00;
  - `stall_count` = 0;
  - `stall` and `flush` evaluate to 0 while `branch_taken` and `id_valid` are 0.
- `stall` and `flush` are combinational from the ID inputs, the slots and `branch_taken`, with zero latency.
- The selects are registered with one-cycle latency. They are valid throughout the cycle the instruction occupies EXE.
- The slots and the counter update on the rising `clk` edge.
- A load-use stall with `fwd_en`=1 lasts exactly 1 cycle.
- A no-forwarding stall lasts 1–2 cycles:
  - 2 when the producer is in E;
  - 1 when it is in M.
- Reset asserted mid-stall: all state clears immediately, and `stall` drops in the same cycle.

## Test plan
- ALU dependency with forwarding: `ADD r1` then `SUB r2,r1,r3` with `fwd_en`=1 → no stall; `sel_src1`=01 while SUB is in EXE.
- Distance-2 dependency: `ADD r1`, an unrelated instruction, then `ORR r4,r5,r1` with `two_src`=1 → `sel_src2`=10 and `sel_src1`=00.
- Load-use: `LDR r2` then `ADD r3,r2,r2` → `stall`=1 for one cycle and a bubble enters EXE. ADD then enters EXE with `sel_src1`=`sel_src2`=10, and `stall_count`=1.
- No forwarding: `fwd_en`=0 with `ADD r1` then `SUB r2,r1,r0` → `stall` held 2 cycles, selects 00, `stall_count`=2.
- Flush vs stall: a load-use condition coincides with `branch_taken`=1 → `flush`=1 and `stall`=0, E becomes a bubble, selects 00, counter unchanged.
- Reset and saturation:
  - Force the counter to 16'hFFFF and stall again → it stays at 16'hFFFF.
  - Assert `rst` low mid-stall → counter 0, selects 00, `stall`=0 asynchronously.
